// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forward-select encodings, stage record layout
// and the producer-match helper used by the forwarding compare.
package pipe_pkg;

    localparam int unsigned REC_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [REC_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
        logic              uses_rt;
    } stage_rec_t;

    // True when a stage with write-enable wen and destination dst produces src.
    function automatic logic fwd_hit(input logic wen, input logic [REC_AW-1:0] dst,
                                     input logic [REC_AW-1:0] src);
        return wen && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Operand-select compare for one EX source register against the EX/MEM and
// MEM/WB producers; the younger EX/MEM producer wins.
module fwd_sel_logic
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REC_AW
) (
    input  logic              i_src_en,
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_mem_wen,
    input  logic [REG_AW-1:0] i_mem_dst,
    input  logic              i_wb_wen,
    input  logic [REG_AW-1:0] i_wb_dst,
    output logic [1:0]        o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_src_en) begin
            if (fwd_hit(i_mem_wen, i_mem_dst, i_src)) begin
                o_sel = FWD_EXMEM;
            end else if (fwd_hit(i_wb_wen, i_wb_dst, i_src)) begin
                o_sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall control for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall/forward statistics counters.
module fwd_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = REC_AW
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] fwd_cnt
`endif
);

    stage_rec_t r_ex, r_mem, r_wb;
    stage_rec_t w_ex_d;
    logic       w_stall;
    logic [1:0] w_sel_a, w_sel_b;

    // Load in EX whose destination the ID instruction reads; flush overrides.
    always_comb begin
        w_stall = id_valid && !flush && r_ex.valid && r_ex.mem_read &&
                  (r_ex.dst != REG_ZERO) &&
                  ((r_ex.dst == id_rs) || (id_uses_rt && (r_ex.dst == id_rt)));
    end

    always_comb begin
        w_ex_d = '0;
        if (id_valid && !w_stall && !flush) begin
            w_ex_d.valid     = 1'b1;
            w_ex_d.dst       = id_dst;
            w_ex_d.reg_write = id_reg_write;
            w_ex_d.mem_read  = id_mem_read;
            w_ex_d.rs        = id_rs;
            w_ex_d.rt        = id_rt;
            w_ex_d.uses_rt   = id_uses_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_ex  <= w_ex_d;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    fwd_sel_logic #(
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .i_src_en  (r_ex.valid),
        .i_src     (r_ex.rs),
        .i_mem_wen (r_mem.valid && r_mem.reg_write),
        .i_mem_dst (r_mem.dst),
        .i_wb_wen  (r_wb.valid && r_wb.reg_write),
        .i_wb_dst  (r_wb.dst),
        .o_sel     (w_sel_a)
    );

    fwd_sel_logic #(
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .i_src_en  (r_ex.valid && r_ex.uses_rt),
        .i_src     (r_ex.rt),
        .i_mem_wen (r_mem.valid && r_mem.reg_write),
        .i_mem_dst (r_mem.dst),
        .i_wb_wen  (r_wb.valid && r_wb.reg_write),
        .i_wb_dst  (r_wb.dst),
        .o_sel     (w_sel_b)
    );

    assign fwd_a_sel  = w_sel_a;
    assign fwd_b_sel  = w_sel_b;
    assign stall      = w_stall;
    assign pc_write   = ~w_stall;
    assign ifid_write = ~w_stall;

    // The WB record only needs its producer fields; the rest just ride along.
    logic w_unused;
    assign w_unused = ^{r_wb.mem_read, r_wb.rs, r_wb.rt, r_wb.uses_rt};

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt, r_fwd_cnt;
    logic              w_fwd_any;

    assign w_fwd_any = (w_sel_a != FWD_RF) || (w_sel_b != FWD_RF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_fwd_any && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: expected selects/stall are queued when an
// ID instruction is driven and checked against the DUT outputs.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       pc_write;
    logic       ifid_write;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
`endif

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       s;
    } exp_t;

    exp_t q_exp[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    fwd_hazard_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] dst, input logic rw,
                       input logic mr, input logic fl);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        id_dst       = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        flush        = fl;
    endtask

    task automatic nop();
        ins(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmp(input string tag, input string what, input logic [1:0] obs,
                       input logic [1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %b expected %b", tag, what, obs, expv);
        end
    endtask

    // Queue expectation for the current cycle, let inputs settle, then check.
    task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                       input logic es);
        exp_t e;
        e.a = ea;
        e.b = eb;
        e.s = es;
        q_exp.push_back(e);
        #1;
        e = q_exp.pop_front();
        cmp(tag, "fwd_a_sel", fwd_a_sel, e.a);
        cmp(tag, "fwd_b_sel", fwd_b_sel, e.b);
        cmp(tag, "stall", {1'b0, stall}, {1'b0, e.s});
        cmp(tag, "pc_write", {1'b0, pc_write}, {1'b0, ~e.s});
        cmp(tag, "ifid_write", {1'b0, ifid_write}, {1'b0, ~e.s});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        // Hazard-looking ID inputs while in reset must not stall.
        ins(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        #3;
        chk("reset", 2'b00, 2'b00, 1'b0);
        nop();
        #4;
        rst_n = 1'b1;
        tick();

        // add $3,$1,$2 ; sub $4,$3,$5
        ins(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); chk("t1_add", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd3, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); chk("t1_sub_id", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t1_sub_ex", 2'b10, 2'b00, 1'b0); tick();
        nop(); chk("t1_drain", 2'b00, 2'b00, 1'b0); tick();

        // add $3 ; nop ; or $6,$5,$3
        ins(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); chk("t2_add", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t2_nop", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0); chk("t2_or_id", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t2_or_ex", 2'b00, 2'b01, 1'b0); tick();
        nop(); chk("t2_drain", 2'b00, 2'b00, 1'b0); tick();

        // lw $2,0($1) ; add $4,$2,$2 -> one stall then MEM/WB forward
        ins(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); chk("t3_lw", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); chk("t3_stall", 2'b00, 2'b00, 1'b1); tick();
        chk("t3_held", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t3_fwd", 2'b01, 2'b01, 1'b0); tick();

        // add $0,$1,$1 ; add $5,$0,$0 ; lw $0 ; add $7,$0,$0
        ins(1'b1, 5'd1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); chk("t4_add0", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); chk("t4_rd0_id", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t4_rd0_ex", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); chk("t4_lw0", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); chk("t4_lw0_use", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t4_use_ex", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t4_drain", 2'b00, 2'b00, 1'b0); tick();

        // add $3 ; add $3 ; sub $7,$3,$3 -> EX/MEM wins
        ins(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); chk("t5_add_a", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); chk("t5_add_b", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd3, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); chk("t5_sub_id", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t5_prio", 2'b10, 2'b10, 1'b0); tick();
        nop(); chk("t5_drain1", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t5_drain2", 2'b00, 2'b00, 1'b0); tick();

        // lw $2 ; add $4,$2,$2 with flush -> no stall, bubble in EX
        ins(1'b1, 5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0); chk("t6_lw", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd2, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1); chk("t6_flush", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t6_bubble", 2'b00, 2'b00, 1'b0); tick();

        // rt match without uses_rt must not forward on B
        ins(1'b1, 5'd1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0); chk("t7_add", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd9, 5'd3, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0); chk("t7_addi_id", 2'b00, 2'b00, 1'b0); tick();
        nop(); chk("t7_addi_ex", 2'b00, 2'b00, 1'b0); tick();

        // lw $5 ; sw $5,0($6) stalls through rt, then async reset mid-stall
        ins(1'b1, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); chk("t8_lw", 2'b00, 2'b00, 1'b0); tick();
        ins(1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); chk("t8_stall_rt", 2'b00, 2'b00, 1'b1);
        #2;
        rst_n = 1'b0;
        chk("t8_rst_mid", 2'b00, 2'b00, 1'b0);
        #2;
        rst_n = 1'b1;
        chk("t8_rst_rel", 2'b00, 2'b00, 1'b0);
        tick();
        nop(); chk("t8_after", 2'b00, 2'b00, 1'b0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
